econet_rx_ring: RTL and testbench

Second-generation Econet receive buffer. It takes the byte/frame-event stream from the Econet receiver, already synchronised into sys_clk upstream, and packs it into a parametrised circular word buffer. Each completed good frame becomes a descriptor in a small FIFO, so several frames can queue before the CPU services them. The CPU reads buffer words and the head descriptor over the system bus, then pops the descriptor to release the frame's buffer space.

---
 rtl/econet_rx_ring.sv | 212 +++++++++++++++++++++
 tb/tb_econet_rx_ring.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/econet_rx_ring.sv
// Econet receive ring: packs received bytes into a circular word buffer and queues good frames as descriptors.
// Optional statistics output enabled by defining ECONET_RX_STATS_EN.
module econet_rx_ring #(
    parameter int          BUF_AW    = 7,
    parameter int          DESC_AW   = 2,
    parameter int          MIN_BYTES = 6,
    parameter logic [15:0] FCS_GOOD  = 16'hF0B8
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic [7:0]          rx_byte,
    input  logic                rx_byte_ready,
    input  logic                rx_frame_start,
    input  logic                rx_frame_end,
    input  logic [15:0]         rx_fcs,
    input  logic                sys_select,
    input  logic                sys_rd,
    input  logic [BUF_AW-1:0]   sys_addr,
    input  logic                sys_pop,
    output logic [31:0]         sys_data,
    output logic [31:0]         sys_frame_start,
    output logic [31:0]         sys_frame_len,
    output logic [DESC_AW:0]    sys_frame_count,
    output logic                sys_frame_valid,
    output logic                sys_overflow,
`ifdef ECONET_RX_STATS_EN
    output logic [31:0]         sys_stats,
`endif
    output logic                receiving
);

    localparam int PW    = BUF_AW + 3;
    localparam int DEPTH = 1 << DESC_AW;
    localparam logic [PW-1:0]      BUF_BYTES_L = PW'(4 * (1 << BUF_AW));
    localparam logic [PW-1:0]      MIN_L       = PW'(MIN_BYTES);
    localparam logic [DESC_AW:0]   DEPTH_L     = (DESC_AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} state_t;

    state_t               state_r, state_s;
    logic [PW-1:0]        wr_ptr_r, frame_base_r, rd_base_r;
    logic [PW-1:0]        ptr_s, base_s, used_s, len_s, push_start_s;
    logic                 we_s, push_s, pop_s, ovf_set_s, full_s;
    logic [31:0]          mem_r [1 << BUF_AW];
    logic [PW-1:0]        desc_start_r [DEPTH];
    logic [PW-1:0]        desc_len_r [DEPTH];
    logic [DESC_AW-1:0]   head_r, tail_r;
    logic [DESC_AW:0]     count_r;
`ifdef ECONET_RX_STATS_EN
    logic                 drop_s;
    logic [15:0]          good_r, dropped_r;
`endif

    assign used_s = wr_ptr_r - rd_base_r;
    assign full_s = (count_r == DEPTH_L);
    assign pop_s  = sys_pop && (count_r != '0);

    // Frame receive decisions; strobes are applied in order byte, end, start.
    always_comb begin
        state_s      = state_r;
        ptr_s        = wr_ptr_r;
        base_s       = frame_base_r;
        we_s         = 1'b0;
        push_s       = 1'b0;
        ovf_set_s    = 1'b0;
        len_s        = '0;
        push_start_s = frame_base_r;
`ifdef ECONET_RX_STATS_EN
        drop_s       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (rx_frame_start) begin
                    base_s  = wr_ptr_r;
                    state_s = RECV;
                end else begin
                    state_s = IDLE;
                end
            end
            RECV, DROP: begin
                if (state_r == RECV && rx_byte_ready) begin
                    if (used_s < BUF_BYTES_L) begin
                        we_s  = 1'b1;
                        ptr_s = wr_ptr_r + PW'(1);
                    end else begin
                        state_s   = DROP;
                        ovf_set_s = 1'b1;
`ifdef ECONET_RX_STATS_EN
                        drop_s    = 1'b1;
`endif
                    end
                end else begin
                    state_s = state_r;
                end
                if (rx_frame_end) begin
                    len_s        = ptr_s - base_s;
                    push_start_s = base_s;
                    if (state_s == RECV && rx_fcs == FCS_GOOD && len_s >= MIN_L && !full_s) begin
                        push_s = 1'b1;
                    end else begin
                        ptr_s = base_s;
                        // All other checks passing means the descriptor FIFO was full.
                        if (state_s == RECV && rx_fcs == FCS_GOOD && len_s >= MIN_L) begin
                            ovf_set_s = 1'b1;
                        end else begin
                            ovf_set_s = ovf_set_s;
                        end
`ifdef ECONET_RX_STATS_EN
                        drop_s = drop_s | (state_s == RECV);
`endif
                    end
                    state_s = IDLE;
                end else begin
                    state_s = state_s;
                end
                if (rx_frame_start) begin
                    if (state_s != IDLE) begin
                        ptr_s = base_s;
`ifdef ECONET_RX_STATS_EN
                        drop_s = drop_s | (state_s == RECV);
`endif
                    end else begin
                        ptr_s = ptr_s;
                    end
                    base_s  = ptr_s;
                    state_s = RECV;
                end else begin
                    base_s = base_s;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Receive state, pointers, descriptor FIFO control and sticky overflow.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            wr_ptr_r     <= '0;
            frame_base_r <= '0;
            rd_base_r    <= '0;
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            sys_overflow <= 1'b0;
            receiving    <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_ptr_r     <= ptr_s;
            frame_base_r <= base_s;
            receiving    <= (state_s != IDLE);
            tail_r       <= push_s ? tail_r + DESC_AW'(1) : tail_r;
            head_r       <= pop_s ? head_r + DESC_AW'(1) : head_r;
            count_r      <= count_r + (DESC_AW+1)'(push_s) - (DESC_AW+1)'(pop_s);
            rd_base_r    <= pop_s ? desc_start_r[head_r] + desc_len_r[head_r] : rd_base_r;
            if (ovf_set_s) begin
                sys_overflow <= 1'b1;
            end else if (sys_select && sys_pop) begin
                sys_overflow <= 1'b0;
            end else begin
                sys_overflow <= sys_overflow;
            end
        end
    end

    // Descriptor storage; contents are only visible while the FIFO is non-empty.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            desc_start_r[tail_r] <= push_start_s;
            desc_len_r[tail_r]   <= len_s;
        end
    end

    // Byte-lane write into the word buffer.
    always_ff @(posedge sys_clk) begin
        if (we_s) begin
            mem_r[wr_ptr_r[BUF_AW+1:2]][{wr_ptr_r[1:0], 3'b000} +: 8] <= rx_byte;
        end
    end

    // Registered CPU read port.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sys_data <= 32'd0;
        end else if (sys_rd && sys_select) begin
            sys_data <= mem_r[sys_addr];
        end else begin
            sys_data <= sys_data;
        end
    end

    assign sys_frame_count = count_r;
    assign sys_frame_valid = (count_r != '0);
    assign sys_frame_start = sys_frame_valid ? 32'(desc_start_r[head_r][PW-2:0]) : 32'd0;
    assign sys_frame_len   = sys_frame_valid ? 32'(desc_len_r[head_r]) : 32'd0;

`ifdef ECONET_RX_STATS_EN
    // Saturating good/dropped frame counters.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            good_r    <= 16'd0;
            dropped_r <= 16'd0;
        end else begin
            good_r    <= (push_s && good_r != 16'hFFFF) ? good_r + 16'd1 : good_r;
            dropped_r <= (drop_s && dropped_r != 16'hFFFF) ? dropped_r + 16'd1 : dropped_r;
        end
    end

    assign sys_stats = {good_r, dropped_r};
`endif

endmodule

// File: tb/tb_econet_rx_ring.sv
// Directed self-checking bench for econet_rx_ring: a default instance plus a 16-byte buffer instance for wrap.
module tb_econet_rx_ring;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_byte_ready = 1'b0;
    logic        rx_frame_start = 1'b0;
    logic        rx_frame_end = 1'b0;
    logic [15:0] rx_fcs = 16'd0;
    logic        sys_select = 1'b0;
    logic        sys_rd = 1'b0;
    logic [6:0]  sys_addr = 7'd0;
    logic        sys_pop = 1'b0;

    logic [31:0] data_a, start_a, len_a, data_b, start_b, len_b;
    logic [2:0]  count_a, count_b;
    logic        valid_a, ovf_a, recv_a, valid_b, ovf_b, recv_b;

    int passed = 0;
    int total  = 0;

    always #5 sys_clk = ~sys_clk;

    econet_rx_ring dut_a (
        .sys_clk(sys_clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_ready(rx_byte_ready),
        .rx_frame_start(rx_frame_start), .rx_frame_end(rx_frame_end), .rx_fcs(rx_fcs),
        .sys_select(sys_select), .sys_rd(sys_rd), .sys_addr(sys_addr), .sys_pop(sys_pop),
        .sys_data(data_a), .sys_frame_start(start_a), .sys_frame_len(len_a),
        .sys_frame_count(count_a), .sys_frame_valid(valid_a), .sys_overflow(ovf_a),
        .receiving(recv_a)
    );

    econet_rx_ring #(.BUF_AW(2)) dut_b (
        .sys_clk(sys_clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_ready(rx_byte_ready),
        .rx_frame_start(rx_frame_start), .rx_frame_end(rx_frame_end), .rx_fcs(rx_fcs),
        .sys_select(sys_select), .sys_rd(sys_rd), .sys_addr(sys_addr[1:0]), .sys_pop(sys_pop),
        .sys_data(data_b), .sys_frame_start(start_b), .sys_frame_len(len_b),
        .sys_frame_count(count_b), .sys_frame_valid(valid_b), .sys_overflow(ovf_b),
        .receiving(recv_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic start_frame();
        rx_frame_start = 1'b1;
        tick();
        rx_frame_start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            rx_byte = first + 8'(i);
            rx_byte_ready = 1'b1;
            tick();
        end
        rx_byte_ready = 1'b0;
    endtask

    task automatic end_frame(input logic [15:0] fcs);
        rx_fcs = fcs;
        rx_frame_end = 1'b1;
        tick();
        rx_frame_end = 1'b0;
    endtask

    task automatic frame(input logic [7:0] first, input int n, input logic [15:0] fcs);
        start_frame();
        send_bytes(first, n);
        end_frame(fcs);
        tick();
    endtask

    task automatic pop();
        sys_select = 1'b1;
        sys_pop = 1'b1;
        tick();
        sys_pop = 1'b0;
        sys_select = 1'b0;
    endtask

    task automatic rd(input logic [6:0] addr);
        sys_select = 1'b1;
        sys_rd = 1'b1;
        sys_addr = addr;
        tick();
        sys_rd = 1'b0;
        sys_select = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_data", data_a, 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_start", start_a, 32'd0);
        check("rst_len", len_a, 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_recv", 32'(recv_a), 32'd0);
        reset = 1'b1;
        tick();

        // Bad FCS rolls back, following good frame starts at 0
        frame(8'h01, 10, 16'h1234);
        check("badfcs_count", 32'(count_a), 32'd0);
        check("badfcs_valid", 32'(valid_a), 32'd0);
        start_frame();
        check("recv_high", 32'(recv_a), 32'd1);
        send_bytes(8'h01, 10);
        end_frame(16'hF0B8);
        check("recv_low", 32'(recv_a), 32'd0);
        check("good_count", 32'(count_a), 32'd1);
        check("good_valid", 32'(valid_a), 32'd1);
        check("good_start", start_a, 32'd0);
        check("good_len", len_a, 32'd10);
        rd(7'd0);
        check("word0", data_a, 32'h04030201);
        rd(7'd1);
        check("word1", data_a, 32'h08070605);
        rd(7'd2);
        check("word2_lo", data_a & 32'h0000FFFF, 32'h00000A09);
        tick();
        check("data_hold", data_a & 32'h0000FFFF, 32'h00000A09);

        // Descriptor FIFO overflow
        do_reset();
        for (int f = 0; f < 5; f++) frame(8'(8'h10 * f), 8, 16'hF0B8);
        check("fifo_full_count", 32'(count_a), 32'd4);
        check("fifo_full_ovf", 32'(ovf_a), 32'd1);
        check("fifo_head", start_a, 32'd0);
        pop();
        check("pop1_start", start_a, 32'd8);
        check("pop1_count", 32'(count_a), 32'd3);
        check("pop1_ovf_clr", 32'(ovf_a), 32'd0);
        frame(8'hA0, 6, 16'hF0B8);
        check("refill_count", 32'(count_a), 32'd4);
        pop();
        pop();
        pop();
        check("rollback_start", start_a, 32'd32);
        check("rollback_len", len_a, 32'd6);
        pop();
        check("drain_valid", 32'(valid_a), 32'd0);
        pop();
        check("empty_pop", 32'(count_a), 32'd0);

        // Wrap in the 16-byte instance
        do_reset();
        frame(8'h10, 12, 16'hF0B8);
        check("wrap_f1_len", len_b, 32'd12);
        pop();
        check("wrap_pop_count", 32'(count_b), 32'd0);
        frame(8'h20, 12, 16'hF0B8);
        check("wrap_start", start_b, 32'd12);
        check("wrap_len", len_b, 32'd12);
        check("wrap_count", 32'(count_b), 32'd1);
        rd(7'd0);
        check("wrap_word0", data_b, 32'h27262524);
        rd(7'd1);
        check("wrap_word1", data_b, 32'h2B2A2928);
        rd(7'd3);
        check("wrap_word3", data_b, 32'h23222120);
        pop();
        frame(8'h40, 17, 16'hF0B8);
        check("bufovf_count", 32'(count_b), 32'd0);
        check("bufovf_flag", 32'(ovf_b), 32'd1);
        check("bufovf_recv", 32'(recv_b), 32'd0);
        check("bufovf_a_ok", 32'(ovf_a), 32'd0);
        pop();
        check("bufovf_clr", 32'(ovf_b), 32'd0);
        frame(8'h50, 16, 16'hF0B8);
        check("exact_fit_count", 32'(count_b), 32'd1);
        check("exact_fit_len", len_b, 32'd16);
        check("exact_fit_start", start_b, 32'd8);

        // Runt, abort and byte+end in one cycle
        do_reset();
        frame(8'h01, 3, 16'hF0B8);
        check("runt_count", 32'(count_a), 32'd0);
        check("runt_ovf", 32'(ovf_a), 32'd0);
        start_frame();
        send_bytes(8'h01, 4);
        start_frame();
        send_bytes(8'h11, 7);
        end_frame(16'hF0B8);
        check("abort_count", 32'(count_a), 32'd1);
        check("abort_len", len_a, 32'd7);
        check("abort_start", start_a, 32'd0);
        start_frame();
        send_bytes(8'h21, 5);
        rx_byte = 8'h26;
        rx_byte_ready = 1'b1;
        rx_fcs = 16'hF0B8;
        rx_frame_end = 1'b1;
        tick();
        rx_byte_ready = 1'b0;
        rx_frame_end = 1'b0;
        check("byte_end_count", 32'(count_a), 32'd2);
        pop();
        check("byte_end_start", start_a, 32'd7);
        check("byte_end_len", len_a, 32'd6);

        // Reset mid-frame with descriptors queued
        do_reset();
        frame(8'h01, 6, 16'hF0B8);
        frame(8'h31, 6, 16'hF0B8);
        check("pre_rst_count", 32'(count_a), 32'd2);
        rd(7'd0);
        check("pre_rst_data", data_a, 32'h04030201);
        start_frame();
        send_bytes(8'h41, 3);
        check("pre_rst_recv", 32'(recv_a), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(count_a), 32'd0);
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_start", start_a, 32'd0);
        check("mid_rst_len", len_a, 32'd0);
        check("mid_rst_data", data_a, 32'd0);
        check("mid_rst_recv", 32'(recv_a), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        frame(8'h61, 6, 16'hF0B8);
        check("post_rst_count", 32'(count_a), 32'd1);
        check("post_rst_start", start_a, 32'd0);
        rd(7'd0);
        check("post_rst_word0", data_a, 32'h64636261);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
